c_buffer_drain: RTL and testbench
=================================

C_BUFFER_DRAIN -- requirements
Module: c_buffer_drain

Interface
REQ-001 The module SHALL have parameter ADDR_BITS, default 16, meaning the C-buffer row address width.
REQ-002 The module SHALL have parameter DATA_BITS, default 128, meaning the C-buffer row width.
REQ-003 The module SHALL have parameter WORD_BITS, default 32, meaning the output word width; DATA_BITS/WORD_BITS = 4 words per row.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The module SHALL have port start, input, 1, a one-cycle request to drain a row range.
REQ-007 The module SHALL have port base_addr, input, ADDR_BITS, the first row index, sampled with start.
REQ-008 The module SHALL have port num_rows, input, ADDR_BITS, the row count, sampled with start.
REQ-009 The module SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-010 The module SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-011 The module SHALL have port buf_index_out, output, ADDR_BITS, the read index driven to the C buffer.
REQ-012 The module SHALL have port buf_out, output, 1, the read enable driven to the C buffer.
REQ-013 The module SHALL have port buf_data, input, DATA_BITS, the C-buffer registered read data.
REQ-014 The module SHALL have port word_valid, output, 1, which is high when word_data holds a valid word.
REQ-015 The module SHALL have port word_ready, input, 1, the consumer accept signal.
REQ-016 The module SHALL have port word_data, output, WORD_BITS, the output word.

Function
REQ-017 The block SHALL implement states IDLE, READ, SEND, FINISH.
REQ-018 In IDLE, start=1 SHALL latch base_addr into row_addr and num_rows into rows_left, and go to READ, or to FINISH if num_rows=0.
REQ-019 While not in IDLE, start SHALL be ignored.
REQ-020 In READ (one cycle) the block SHALL drive buf_out=1 and buf_index_out=row_addr; buf_out SHALL be 0 in all other states.
REQ-021 The C buffer captures on the falling edge, so the rising edge ending READ SHALL latch buf_data into a DATA_BITS row register and enter SEND with word_cnt=0.
REQ-022 In SEND the block SHALL drive word_valid=1 and word_data = row_reg[word_cnt*WORD_BITS +: WORD_BITS], so that bits [31:0] are sent first.
REQ-023 A transfer SHALL occur on a rising edge with word_valid=1 and word_ready=1, and SHALL increment word_cnt.
REQ-024 word_data and word_valid SHALL remain stable while word_valid=1 and word_ready=0.
REQ-025 On the transfer of word 3, the block SHALL decrement rows_left and increment row_addr modulo 2^ADDR_BITS (0xFFFF wraps to 0x0000).
REQ-026 On that same transfer, the block SHALL go to READ if rows_left was greater than 1, else to FINISH.
REQ-027 FINISH SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-028 busy SHALL be 1 in READ and SEND, and 0 in IDLE and FINISH.
REQ-029 Throughput with word_ready held high SHALL be 5 cycles per row (1 READ + 4 SEND).
REQ-030 Latency from an accepted start to the first word_valid SHALL be 2 cycles.

Reset
REQ-031 When rst=1 at a rising edge, the block SHALL enter IDLE and clear row_addr, rows_left, word_cnt and row_reg.
REQ-032 During and after reset, the outputs SHALL be busy=0, done=0, buf_out=0, buf_index_out=0, word_valid=0 and word_data=0.
REQ-033 rst SHALL take priority over start and over any transfer in the same cycle.
REQ-034 A reset mid-drain SHALL abandon the operation without a done pulse.

Verification
REQ-035 Single row: preload row 5 = 0x44444444_33333333_22222222_11111111, start with base=5, num=1, ready=1 -> buf_out high for 1 cycle with index 5; words 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles; done pulses 1 cycle later.
REQ-036 Backpressure: same setup, with ready low for 3 cycles after the first word_valid -> word_data holds 0x11111111 throughout, and no word is lost or duplicated.
REQ-037 Wrap: start with base=0xFFFF, num=2 -> reads at index 0xFFFF then 0x0000, 8 words, one done pulse.
REQ-038 Zero rows: start with num=0 -> no buf_out, no word_valid, done on the cycle after start.
REQ-039 Reset mid-drain: rst asserted after the 2nd word of a 3-row drain -> all outputs reach their reset values next cycle with no done pulse; a new start with base=7, num=1 drains row 7 correctly.
REQ-040 Start while busy: a second start pulse issued during SEND -> it is ignored, and only the original range is drained.

Source files
------------

// File: rtl/c_buffer_drain_if.sv
// -----------------------------------------------------------------------------
// c_buffer_drain_if
//
// Purpose
//   Groups the two bus-level connections of the C-buffer drain engine:
//     * the read port toward the C buffer (index, read enable, read data)
//     * the word stream toward the consumer (valid / ready / data)
//
// Signals
//   buf_index_out  [ADDR_BITS] drain -> buffer  row index to read
//   buf_out        [1]         drain -> buffer  read enable
//   buf_data       [DATA_BITS] buffer -> drain  registered read data
//   word_valid     [1]         drain -> sink    word_data holds a valid word
//   word_ready     [1]         sink  -> drain   consumer accepts the word
//   word_data      [WORD_BITS] drain -> sink    output word
//
// Modports
//   master : the drain engine side
//   slave  : the C buffer + consumer side (testbench / surrounding logic)
// -----------------------------------------------------------------------------
interface c_buffer_drain_if #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 128,
  parameter int WORD_BITS = 32
);

  logic [ADDR_BITS-1:0] buf_index_out;
  logic                 buf_out;
  logic [DATA_BITS-1:0] buf_data;

  logic                 word_valid;
  logic                 word_ready;
  logic [WORD_BITS-1:0] word_data;

  modport master (
    output buf_index_out,
    output buf_out,
    input  buf_data,
    output word_valid,
    input  word_ready,
    output word_data
  );

  modport slave (
    input  buf_index_out,
    input  buf_out,
    output buf_data,
    input  word_valid,
    output word_ready,
    input  word_data
  );

endinterface : c_buffer_drain_if

// File: rtl/c_buffer_drain.sv
// -----------------------------------------------------------------------------
// c_buffer_drain
//
// Purpose
//   Drains a contiguous range of rows from the C buffer and streams each row
//   out as DATA_BITS/WORD_BITS words over a valid/ready handshake, lowest
//   word first. Row indices wrap modulo 2^ADDR_BITS.
//
//   Per row the engine spends one READ cycle (read enable + index to the
//   buffer; the buffer captures on the falling edge so its data is ready at
//   the rising edge that ends READ) followed by one SEND cycle per word when
//   the consumer never stalls.
//
// Ports
//   clk        in   1          single clock, rising-edge state updates
//   rst        in   1          synchronous active-high reset
//   start      in   1          one-cycle drain request (ignored unless idle)
//   base_addr  in   ADDR_BITS  first row index, sampled with start
//   num_rows   in   ADDR_BITS  number of rows, sampled with start
//   busy       out  1          high in READ and SEND
//   done       out  1          one-cycle completion pulse (FINISH state)
//   bus        master modport of c_buffer_drain_if
//                   (buf_index_out, buf_out, buf_data,
//                    word_valid, word_ready, word_data)
// -----------------------------------------------------------------------------
module c_buffer_drain #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 128,
  parameter int WORD_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [ADDR_BITS-1:0] num_rows,
  output logic                 busy,
  output logic                 done,
  c_buffer_drain_if.master     bus
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int WORDS    = DATA_BITS / WORD_BITS;
  // Keep the counter at least one bit wide so a one-word row still elaborates.
  localparam int CNT_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [CNT_BITS-1:0]  LAST_WORD = CNT_BITS'(WORDS - 1);
  localparam logic [ADDR_BITS-1:0] ONE_ROW   = ADDR_BITS'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    FINISH
  } state_t;

  state_t state, state_next;

  logic [ADDR_BITS-1:0]              row_addr;
  logic [ADDR_BITS-1:0]              rows_left;
  logic [CNT_BITS-1:0]               word_cnt;
  // Row held as a packed array of words so word selection is a plain index.
  logic [WORDS-1:0][WORD_BITS-1:0]   row_reg;

  logic last_word;
  logic transfer;

  assign last_word = (word_cnt == LAST_WORD);
  assign transfer  = (state == SEND) && bus.word_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          // An empty range skips straight to the completion pulse.
          state_next = (num_rows == '0) ? FINISH : READ;
        end
      end

      READ: begin
        state_next = SEND;
      end

      SEND: begin
        if (transfer && last_word) begin
          // rows_left still counts the row being finished here.
          state_next = (rows_left > ONE_ROW) ? READ : FINISH;
        end
      end

      FINISH: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: row_reg is an ordinary register (not a RAM), so it is cleared by
  // reset together with the counters; stale row data never reaches word_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_addr  <= '0;
      rows_left <= '0;
      word_cnt  <= '0;
      row_reg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            row_addr  <= base_addr;
            rows_left <= num_rows;
          end
        end

        READ: begin
          // Buffer has captured on the falling edge inside READ; take it now.
          row_reg  <= bus.buf_data;
          word_cnt <= '0;
        end

        SEND: begin
          if (transfer) begin
            word_cnt <= word_cnt + CNT_BITS'(1);
            if (last_word) begin
              rows_left <= rows_left - ONE_ROW;
              // Natural ADDR_BITS overflow gives the required wrap to zero.
              row_addr  <= row_addr + ONE_ROW;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Decoded from state. Gating with rst holds every output at its reset value
  // for the whole reset window, including the cycle before the reset edge.
  always_comb begin
    busy              = 1'b0;
    done              = 1'b0;
    bus.buf_out       = 1'b0;
    bus.buf_index_out = '0;
    bus.word_valid    = 1'b0;
    bus.word_data     = '0;

    if (!rst) begin
      unique case (state)
        READ: begin
          busy              = 1'b1;
          bus.buf_out       = 1'b1;
          bus.buf_index_out = row_addr;
        end

        SEND: begin
          // row_reg and word_cnt only move on a transfer, so the word stays
          // stable while the consumer stalls.
          busy           = 1'b1;
          bus.word_valid = 1'b1;
          bus.word_data  = row_reg[word_cnt];
        end

        FINISH: begin
          done = 1'b1;
        end

        default: begin
        end
      endcase
    end
  end

endmodule : c_buffer_drain

// File: tb/tb_c_buffer_drain.sv
// -----------------------------------------------------------------------------
// tb_c_buffer_drain
//
// Self-checking bench for c_buffer_drain. A behavioural model turns every
// accepted start into the list of expected buffer reads and output words
// (computed from the row range with plain address arithmetic); a monitor on
// the falling edge pops and compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_c_buffer_drain;

  localparam int AB  = 16;
  localparam int DB  = 128;
  localparam int WB  = 32;
  localparam int WPR = DB / WB;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AB-1:0] base_addr;
  logic [AB-1:0] num_rows;
  logic          busy;
  logic          done;

  c_buffer_drain_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .WORD_BITS(WB)) bus ();

  c_buffer_drain #(.ADDR_BITS(AB), .DATA_BITS(DB), .WORD_BITS(WB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // C buffer model: sparse preloads, deterministic pattern elsewhere.
  // Captures on the falling edge while read enable is high.
  // ---------------------------------------------------------------------------
  logic [DB-1:0] mem [int];

  function automatic logic [DB-1:0] row_of(input logic [AB-1:0] a);
    logic [15:0] a3;
    if (mem.exists(int'(a))) return mem[int'(a)];
    a3 = 16'(a * 3);
    return {a, 16'hA5A5, ~a, 16'h5A5A, a ^ 16'h1234, 16'h0F0F, a3, 16'hC3C3};
  endfunction

  always @(negedge clk) begin
    if (bus.buf_out) bus.buf_data <= row_of(bus.buf_index_out);
  end

  // ---------------------------------------------------------------------------
  // Reference model + scoreboard queues
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [WB-1:0] w;
    bit            first;
    bit            last;
  } exp_word_t;

  exp_word_t     word_q[$];
  logic [AB-1:0] idx_q[$];
  int            done_pending = 0;

  int first_word_cyc = 0;
  int done_cyc       = 0;
  int words_seen     = 0;

  task automatic model_push(input logic [AB-1:0] b, input logic [AB-1:0] n);
    logic [AB-1:0] a;
    logic [DB-1:0] row;
    for (int r = 0; r < int'(n); r++) begin
      a   = AB'(int'(b) + r);
      row = row_of(a);
      idx_q.push_back(a);
      for (int w = 0; w < WPR; w++) begin
        word_q.push_back('{row[w*WB +: WB], (r == 0 && w == 0),
                           (r == int'(n) - 1 && w == WPR - 1)});
      end
    end
    done_pending++;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  bit prev_last = 1'b0;

  always @(negedge clk) begin
    bit cur_last;
    exp_word_t e;
    cur_last = 1'b0;
    if (rst) begin
      // Abandoned drain: nothing outstanding is expected any more.
      word_q.delete();
      idx_q.delete();
      done_pending = 0;
      prev_last    = 1'b0;
    end else begin
      if (bus.buf_out) begin
        if (idx_q.size() == 0) check("spurious_read", bus.buf_out, 1'b0);
        else                   check("read_index", bus.buf_index_out, idx_q.pop_front());
      end

      if (bus.word_valid) begin
        check("busy_in_send", busy, 1'b1);
        if (word_q.size() == 0) begin
          check("spurious_word", bus.word_valid, 1'b0);
        end else if (bus.word_ready) begin
          e = word_q.pop_front();
          check("word_data", bus.word_data, e.w);
          cur_last = e.last;
          if (e.first) first_word_cyc = cyc;
          words_seen++;
        end else begin
          check("word_hold", bus.word_data, word_q[0].w);
        end
      end

      if (prev_last) check("done_after_last", done, 1'b1);
      if (done) begin
        check("busy_in_finish", busy, 1'b0);
        if (done_pending == 0) check("spurious_done", done, 1'b0);
        else done_pending--;
        done_cyc = cyc;
      end
      prev_last = cur_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Consumer ready driver: 0 = always ready, 1 = random, 2 = manual
  // ---------------------------------------------------------------------------
  int ready_mode = 0;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      bus.word_ready = 1'b1;
    else if (ready_mode == 1) bus.word_ready = 1'($urandom_range(0, 1));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all entered and left just after a rising edge)
  // ---------------------------------------------------------------------------
  int start_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AB-1:0] b, input logic [AB-1:0] n, input bit accept);
    start     = 1'b1;
    base_addr = b;
    num_rows  = n;
    start_cyc = cyc;
    if (accept) model_push(b, n);
    tick();
    start     = 1'b0;
    base_addr = $urandom();
    num_rows  = $urandom();
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      if (word_q.size() == 0 && idx_q.size() == 0 && done_pending == 0) break;
      tick();
    end
    if (k == 2000) check({name, "_timeout"}, DB'(done_pending + word_q.size()), '0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},       busy,              1'b0);
    check({tag, "_done"},       done,              1'b0);
    check({tag, "_buf_out"},    bus.buf_out,       1'b0);
    check({tag, "_buf_index"},  bus.buf_index_out, '0);
    check({tag, "_word_valid"}, bus.word_valid,    1'b0);
    check({tag, "_word_data"},  bus.word_data,     '0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    base_addr      = '0;
    num_rows       = '0;
    bus.word_ready = 1'b0;
    bus.buf_data   = '0;

    // Reset values, during and after reset.
    repeat (2) @(posedge clk);
    #1;
    check_idle("in_reset");
    rst = 1'b0;
    tick();
    check_idle("after_reset");

    // Single row, ready held high: timing and word order.
    mem[5] = 128'h44444444_33333333_22222222_11111111;
    ready_mode = 0;
    tick();
    issue(16'd5, 16'd1, 1'b1);
    check("single_busy_read", busy, 1'b1);
    check("single_buf_out", bus.buf_out, 1'b1);
    check("single_index", bus.buf_index_out, 16'd5);
    wait_drain("single");
    check("single_latency", DB'(first_word_cyc - start_cyc), DB'(2));
    check("single_throughput", DB'(done_cyc - first_word_cyc), DB'(5 * 1 - 1));
    check_idle("single_idle");

    // Backpressure: ready low for 3 cycles after the first word_valid.
    ready_mode     = 2;
    bus.word_ready = 1'b0;
    issue(16'd5, 16'd1, 1'b1);
    tick();
    check("bp_first_valid", bus.word_valid, 1'b1);
    check("bp_first_word", bus.word_data, 32'h11111111);
    tick();
    tick();
    check("bp_still_held", bus.word_data, 32'h11111111);
    bus.word_ready = 1'b1;
    wait_drain("backpressure");
    ready_mode = 0;

    // Wrap from the top of the address space.
    issue(16'hFFFF, 16'd2, 1'b1);
    wait_drain("wrap");
    check("wrap_throughput", DB'(done_cyc - first_word_cyc), DB'(5 * 2 - 1));

    // Zero rows: only a done pulse, on the cycle after start.
    issue(16'd9, 16'd0, 1'b1);
    check("zero_done", done, 1'b1);
    check("zero_no_read", bus.buf_out, 1'b0);
    wait_drain("zero");
    check("zero_done_cycle", DB'(done_cyc - start_cyc), DB'(1));

    // Reset after the 2nd word of a 3-row drain, then a fresh drain of row 7.
    begin
      int w0;
      int k;
      w0 = words_seen;
      issue(16'd100, 16'd3, 1'b1);
      for (k = 0; k < 50; k++) begin
        if (words_seen >= w0 + 2) break;
        tick();
      end
      if (k == 50) check("midreset_timeout", DB'(words_seen - w0), DB'(2));
      rst = 1'b1;
      tick();
      check_idle("midreset");
      rst = 1'b0;
      tick();
      check_idle("post_midreset");
      repeat (4) tick();
      mem[7] = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
      issue(16'd7, 16'd1, 1'b1);
      wait_drain("after_reset_drain");
    end

    // Start while busy: the second request must be ignored.
    begin
      int k;
      issue(16'd20, 16'd2, 1'b1);
      for (k = 0; k < 20; k++) begin
        if (bus.word_valid) break;
        tick();
      end
      check("busy_start_valid", bus.word_valid, 1'b1);
      issue(16'd300, 16'd5, 1'b0);
      wait_drain("busy_start");
      repeat (10) tick();
      check_idle("busy_start_idle");
    end

    // Randomized drains with random backpressure and stray starts.
    ready_mode = 1;
    for (int j = 0; j < 30; j++) begin
      logic [AB-1:0] b;
      logic [AB-1:0] n;
      b = ($urandom_range(0, 3) == 0) ? AB'(16'hFFFF - $urandom_range(0, 2)) : AB'($urandom());
      n = AB'($urandom_range(0, 4));
      issue(b, n, 1'b1);
      if (n != 0 && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 6)) tick();
        issue(AB'($urandom()), AB'($urandom_range(1, 3)), 1'b0);
      end
      wait_drain("random");
      repeat ($urandom_range(0, 3)) tick();
    end
    ready_mode = 0;
    repeat (5) tick();
    check("final_words_left", DB'(word_q.size()), '0);
    check("final_done_left", DB'(done_pending), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_c_buffer_drain
